// File: rtl/magnetron_timer_ctrl_if.sv
// Control/status bundle between a cook-timer front panel and the
// magnetron timer controller. The slave side is the controller itself.
interface magnetron_timer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             door_closed;
  logic             load;
  logic [WIDTH-1:0] time_in;
  logic             s;
  logic             r;
  logic [WIDTH-1:0] remaining;
  logic             done;
  logic [2:0]       state_o;

  modport master (
    output tick, start, stop, door_closed, load, time_in,
    input  s, r, remaining, done, state_o
  );

  modport slave (
    input  tick, start, stop, door_closed, load, time_in,
    output s, r, remaining, done, state_o
  );
endinterface

// File: rtl/magnetron_timer_ctrl.sv
// Magnetron cook timer: counts down seconds on a 1 Hz strobe and drives
// one-cycle set/reset pulses into the external magnetron SR latch.
// Every output is a register, so s/r/state follow the sampled inputs by
// exactly one clock edge. The r pulse issued on leaving INIT clears the
// latch after any reset, including one that interrupted a cook cycle.
module magnetron_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  magnetron_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             s_reg, s_next;
  logic             r_reg, r_next;
  logic             done_reg, done_next;

  // Open-start condition shared by IDLE and PAUSE: stop always wins.
  logic start_ok;
  assign start_ok = bus.start && bus.door_closed && !bus.stop;

  // State, counter and pulse registers; reset is asynchronous and forces all quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      rem_reg   <= '0;
      s_reg     <= 1'b0;
      r_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      s_reg     <= s_next;
      r_reg     <= r_next;
      done_reg  <= done_next;
    end
  end

  // Next-state, counter update and pulse decisions, highest priority first.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    s_next     = 1'b0;
    r_next     = 1'b0;

    case (state_reg)
      ST_INIT: begin
        state_next = ST_IDLE;
        r_next     = 1'b1;
      end

      ST_IDLE: begin
        // A load in the same cycle as start shadows the start.
        if (bus.load) begin
          rem_next = bus.time_in;
        end else if (start_ok && (rem_reg != '0)) begin
          state_next = ST_COOK;
          s_next     = 1'b1;
        end
      end

      ST_COOK: begin
        if (bus.stop || !bus.door_closed) begin
          state_next = ST_PAUSE;
          r_next     = 1'b1;
        end else if (bus.tick && (rem_reg != '0)) begin
          rem_next = rem_reg - WIDTH'(1);
          if (rem_reg == WIDTH'(1)) begin
            state_next = ST_DONE;
            r_next     = 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          rem_next   = '0;
        end else if (start_ok) begin
          state_next = ST_COOK;
          s_next     = 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.start || bus.stop) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_INIT;
        rem_next   = '0;
      end
    endcase

    done_next = (state_next == ST_DONE);
  end

  assign bus.s         = s_reg;
  assign bus.r         = r_reg;
  assign bus.remaining = rem_reg;
  assign bus.done      = done_reg;
  assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_magnetron_timer_ctrl.sv
// Bench for magnetron_timer_ctrl: directed vector table, hand-written reset
// sequences, then randomized traffic against a rule-based reference model.
module tb_magnetron_timer_ctrl;

  localparam int W = 8;

  // Debug encoding of state_o as documented for the controller.
  localparam int ST_INIT  = 0;
  localparam int ST_IDLE  = 1;
  localparam int ST_COOK  = 2;
  localparam int ST_PAUSE = 3;
  localparam int ST_DONE  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  magnetron_timer_ctrl_if #(.WIDTH(W)) bus ();

  magnetron_timer_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tick;
    logic start;
    logic stop;
    logic door;
    logic load;
    int   time_in;
    int   s;
    int   r;
    int   rem;
    int   done;
    int   st;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int es, input int er,
                           input int erem, input int edone, input int est);
    check({tag, ".s"},         int'(bus.s), es);
    check({tag, ".r"},         int'(bus.r), er);
    check({tag, ".remaining"}, int'(bus.remaining), erem);
    check({tag, ".done"},      int'(bus.done), edone);
    check({tag, ".state"},     int'(bus.state_o), est);
    check({tag, ".s_r_excl"},  int'(bus.s & bus.r), 0);
  endtask

  task automatic drive(input logic tk, input logic st, input logic sp,
                       input logic dc, input logic ld, input int t);
    bus.tick        = tk;
    bus.start       = st;
    bus.stop        = sp;
    bus.door_closed = dc;
    bus.load        = ld;
    bus.time_in     = t[W-1:0];
  endtask

  // Advance one active edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the controller's rules in plain terms.
  int m_mode;
  int m_rem;
  int m_s;
  int m_r;

  task automatic model_step(input logic tk, input logic st, input logic sp,
                            input logic dc, input logic ld, input int t);
    m_s = 0;
    m_r = 0;
    if (m_mode == ST_INIT) begin
      m_mode = ST_IDLE;
      m_r    = 1;
    end else if (m_mode == ST_IDLE) begin
      if (ld) m_rem = t;
      else if (st && dc && !sp && m_rem > 0) begin
        m_mode = ST_COOK;
        m_s    = 1;
      end
    end else if (m_mode == ST_COOK) begin
      if (sp || !dc) begin
        m_mode = ST_PAUSE;
        m_r    = 1;
      end else if (tk && m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode = ST_DONE;
          m_r    = 1;
        end
      end
    end else if (m_mode == ST_PAUSE) begin
      if (sp) begin
        m_mode = ST_IDLE;
        m_rem  = 0;
      end else if (st && dc) begin
        m_mode = ST_COOK;
        m_s    = 1;
      end
    end else if (m_mode == ST_DONE) begin
      if (st || sp) m_mode = ST_IDLE;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            tick start stop door load  t   s  r rem done state
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 0, 3, 0, ST_IDLE};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 3, 0, ST_COOK};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3, 0, ST_COOK};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 2, 0, ST_COOK};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0, ST_COOK};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 1, ST_DONE};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1, ST_DONE};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9, 0, 0, 0, 1, ST_DONE};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, ST_IDLE};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 0, 0, 5, 0, ST_IDLE};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 5, 0, ST_COOK};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 5, 0, ST_PAUSE};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 5, 0, ST_PAUSE};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 5, 0, ST_COOK};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 4, 0, ST_COOK};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1, 4, 0, ST_PAUSE};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, ST_IDLE};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, ST_IDLE};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 0, 4, 0, ST_IDLE};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 4, 0, ST_IDLE};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4, 0, ST_IDLE};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 4, 0, ST_COOK};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9, 0, 0, 4, 0, ST_COOK};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3, 0, ST_COOK};

    // Power-on reset: outputs quiet before any clock edge.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    check_all("por_async", 0, 0, 0, 0, ST_INIT);
    step();
    step();
    check_all("por_held", 0, 0, 0, 0, ST_INIT);

    // Release: one r pulse leaving INIT, then quiet IDLE.
    #2 rst_n = 1'b1;
    step();
    check_all("init_pulse", 0, 1, 0, 0, ST_IDLE);
    step();
    check_all("init_after", 0, 0, 0, 0, ST_IDLE);

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].door,
            vecs[i].load, vecs[i].time_in);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].r, vecs[i].rem,
                vecs[i].done, vecs[i].st);
    end

    // Asynchronous reset in the middle of a cook cycle (remaining=3).
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all("cook_rst_async", 0, 0, 0, 0, ST_INIT);
    #2 rst_n = 1'b1;
    step();
    check_all("cook_rst_init", 0, 1, 0, 0, ST_IDLE);
    step();
    check_all("cook_rst_idle", 0, 0, 0, 0, ST_IDLE);

    // Randomized traffic against the reference model.
    m_mode = ST_IDLE;
    m_rem  = 0;
    for (int n = 0; n < 1500; n++) begin
      logic tk, st, sp, dc, ld;
      int   t;
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 7) == 0);
      dc = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 7) == 0);
      t  = (n % 97 == 0) ? 255 : int'($urandom_range(0, 6));
      drive(tk, st, sp, dc, ld, t);
      model_step(tk, st, sp, dc, ld, t);
      step();
      check_all($sformatf("rnd%0d", n), m_s, m_r, m_rem,
                (m_mode == ST_DONE) ? 1 : 0, m_mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
